// File: rtl/core_pkg.sv
// Shared core types: vector register index, in-flight instruction ID and the
// decoded instruction record passed from the decoder through the scoreboard.
package core_pkg;

  localparam int unsigned NrVReg    = 32;
  localparam int unsigned InsnIDNum = 8;

  typedef logic [$clog2(NrVReg)-1:0]    vreg_t;
  typedef logic [$clog2(InsnIDNum)-1:0] insn_id_t;

  typedef struct packed {
    logic [7:0] op;
    insn_id_t   insn_id;
    logic [1:0] use_vs;
    vreg_t      vd;
    vreg_t      vs2;
    vreg_t      vs1;
  } issue_req_t;

endpackage

// File: rtl/vinsn_scoreboard.sv
// Vector instruction scoreboard: holds one decoded instruction, blocks it on
// RAW/WAW/ID-reuse hazards and tracks pending vd writes per in-flight ID.
module vinsn_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned NrVReg    = core_pkg::NrVReg,
  parameter int unsigned InsnIDNum = core_pkg::InsnIDNum
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              issue_req_valid_i,
  output logic              issue_req_ready_o,
  input  issue_req_t        issue_req_i,
  output logic              launch_valid_o,
  input  logic              launch_ready_i,
  output issue_req_t        launch_req_o,
  input  logic              done_i,
  input  insn_id_t          done_insn_id_i,
  output logic [NrVReg-1:0] busy_o,
  output logic              spurious_done_o,
  output logic [15:0]       stall_cnt_o
);

  logic                 hold_valid_q;
  issue_req_t           hold_q;
  logic [NrVReg-1:0]    busy_q, busy_d;
  logic [InsnIDNum-1:0] tbl_valid_q, tbl_valid_d;
  vreg_t                tbl_vd_q [InsnIDNum];
  logic                 spurious_q;
  logic [15:0]          stall_cnt_q;

  logic hazard;
  logic issue_fire, launch_fire, done_hit;

  // Hazard sees registered state only; a same-cycle done does not bypass.
  always_comb begin
    hazard = 1'b0;
    if (hold_q.use_vs[0] && busy_q[hold_q.vs1]) hazard = 1'b1;
    if (hold_q.use_vs[1] && busy_q[hold_q.vs2]) hazard = 1'b1;
    if (busy_q[hold_q.vd])                      hazard = 1'b1;
    if (tbl_valid_q[hold_q.insn_id])            hazard = 1'b1;
  end

  assign launch_valid_o    = hold_valid_q && !hazard;
  assign launch_req_o      = hold_q;
  assign launch_fire       = launch_valid_o && launch_ready_i;
  assign issue_req_ready_o = !hold_valid_q || launch_fire;
  assign issue_fire        = issue_req_valid_i && issue_req_ready_o;
  assign done_hit          = done_i && tbl_valid_q[done_insn_id_i];

  // A launching vd is never busy and a done never targets the launching ID,
  // so clearing before setting cannot lose an update.
  always_comb begin
    busy_d      = busy_q;
    tbl_valid_d = tbl_valid_q;
    if (done_hit) begin
      busy_d[tbl_vd_q[done_insn_id_i]] = 1'b0;
      tbl_valid_d[done_insn_id_i]      = 1'b0;
    end
    if (launch_fire) begin
      busy_d[hold_q.vd]           = 1'b1;
      tbl_valid_d[hold_q.insn_id] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_valid_q <= 1'b0;
      busy_q       <= '0;
      tbl_valid_q  <= '0;
      spurious_q   <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      if (issue_fire)       hold_valid_q <= 1'b1;
      else if (launch_fire) hold_valid_q <= 1'b0;
      busy_q      <= busy_d;
      tbl_valid_q <= tbl_valid_d;
      spurious_q  <= done_i && !tbl_valid_q[done_insn_id_i];
      if (hold_valid_q && hazard && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  // Payload flops carry no reset; their valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (issue_fire)  hold_q <= issue_req_i;
    if (launch_fire) tbl_vd_q[hold_q.insn_id] <= hold_q.vd;
  end

  assign busy_o          = busy_q;
  assign spurious_done_o = spurious_q;
  assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_vinsn_scoreboard.sv
// Directed vector bench for vinsn_scoreboard: per-cycle stimulus with
// hand-computed expected outputs, plus a mid-operation reset sequence.
module tb_vinsn_scoreboard;
  import core_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_req_valid_i;
  logic        issue_req_ready_o;
  issue_req_t  issue_req_i;
  logic        launch_valid_o;
  logic        launch_ready_i;
  issue_req_t  launch_req_o;
  logic        done_i;
  insn_id_t    done_insn_id_i;
  logic [31:0] busy_o;
  logic        spurious_done_o;
  logic [15:0] stall_cnt_o;

  always #5 clk_i = ~clk_i;

  vinsn_scoreboard dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .issue_req_valid_i (issue_req_valid_i),
    .issue_req_ready_o (issue_req_ready_o),
    .issue_req_i       (issue_req_i),
    .launch_valid_o    (launch_valid_o),
    .launch_ready_i    (launch_ready_i),
    .launch_req_o      (launch_req_o),
    .done_i            (done_i),
    .done_insn_id_i    (done_insn_id_i),
    .busy_o            (busy_o),
    .spurious_done_o   (spurious_done_o),
    .stall_cnt_o       (stall_cnt_o)
  );

  typedef struct packed {
    logic        iv;
    logic [4:0]  vs1, vs2, vd;
    logic [1:0]  use_vs;
    logic [2:0]  id;
    logic        lr;
    logic        dn;
    logic [2:0]  did;
    logic        e_rdy;
    logic        e_lv;
    logic [31:0] e_busy;
    logic        e_sp;
    logic [15:0] e_stall;
    logic [4:0]  e_vd;
    logic [2:0]  e_id;
  } vec_t;

  localparam int NV = 46;
  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t V(input logic iv, input int vs1, input int vs2, input int vd,
                             input int use_vs, input int id, input logic lr, input logic dn,
                             input int did, input logic rdy, input logic lv, input int busy,
                             input logic sp, input int stall, input int evd, input int eid);
    vec_t v;
    v.iv = iv; v.vs1 = 5'(vs1); v.vs2 = 5'(vs2); v.vd = 5'(vd);
    v.use_vs = 2'(use_vs); v.id = 3'(id); v.lr = lr; v.dn = dn; v.did = 3'(did);
    v.e_rdy = rdy; v.e_lv = lv; v.e_busy = 32'(busy); v.e_sp = sp;
    v.e_stall = 16'(stall); v.e_vd = 5'(evd); v.e_id = 3'(eid);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    //            iv vs1 vs2 vd use id lr dn did  rdy lv busy    sp stall evd eid
    vecs[0]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 'h0,   0, 0, 0, 0);
    vecs[1]  = V(1, 0, 0, 3, 0, 0, 1, 0, 0,  1, 0, 'h0,   0, 0, 0, 0);
    vecs[2]  = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 'h0,   0, 0, 3, 0);
    vecs[3]  = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 'h8,   0, 0, 0, 0);
    vecs[4]  = V(0, 0, 0, 0, 0, 0, 1, 1, 0,  1, 0, 'h8,   0, 0, 0, 0);
    vecs[5]  = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 'h0,   0, 0, 0, 0);
    vecs[6]  = V(0, 0, 0, 0, 0, 0, 1, 1, 7,  1, 0, 'h0,   0, 0, 0, 0);
    vecs[7]  = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 'h0,   1, 0, 0, 0);
    vecs[8]  = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 'h0,   0, 0, 0, 0);
    vecs[9]  = V(1, 0, 0, 5, 0, 1, 1, 0, 0,  1, 0, 'h0,   0, 0, 0, 0);
    vecs[10] = V(1, 0, 5, 6, 2, 2, 1, 0, 0,  1, 1, 'h0,   0, 0, 5, 1);
    vecs[11] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 'h20,  0, 0, 0, 0);
    vecs[12] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 'h20,  0, 1, 0, 0);
    vecs[13] = V(0, 0, 0, 0, 0, 0, 1, 1, 1,  0, 0, 'h20,  0, 2, 0, 0);
    vecs[14] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 'h0,   0, 3, 6, 2);
    vecs[15] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 'h40,  0, 3, 0, 0);
    vecs[16] = V(0, 0, 0, 0, 0, 0, 1, 1, 2,  1, 0, 'h40,  0, 3, 0, 0);
    vecs[17] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 'h0,   0, 3, 0, 0);
    vecs[18] = V(1, 0, 0, 7, 0, 4, 1, 0, 0,  1, 0, 'h0,   0, 3, 0, 0);
    vecs[19] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 'h0,   0, 3, 7, 4);
    vecs[20] = V(1, 0, 0, 8, 0, 4, 1, 0, 0,  1, 0, 'h80,  0, 3, 0, 0);
    vecs[21] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 'h80,  0, 3, 0, 0);
    vecs[22] = V(0, 0, 0, 0, 0, 0, 1, 1, 4,  0, 0, 'h80,  0, 4, 0, 0);
    vecs[23] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 'h0,   0, 5, 8, 4);
    vecs[24] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 'h100, 0, 5, 0, 0);
    vecs[25] = V(0, 0, 0, 0, 0, 0, 1, 1, 4,  1, 0, 'h100, 0, 5, 0, 0);
    vecs[26] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 'h0,   0, 5, 0, 0);
    vecs[27] = V(1, 0, 0, 9, 0, 5, 0, 0, 0,  1, 0, 'h0,   0, 5, 0, 0);
    vecs[28] = V(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 'h0,   0, 5, 9, 5);
    vecs[29] = V(1, 0, 0,10, 0, 6, 0, 0, 0,  0, 1, 'h0,   0, 5, 9, 5);
    vecs[30] = V(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 'h0,   0, 5, 9, 5);
    vecs[31] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 'h0,   0, 5, 9, 5);
    vecs[32] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 'h200, 0, 5, 0, 0);
    vecs[33] = V(0, 0, 0, 0, 0, 0, 1, 1, 5,  1, 0, 'h200, 0, 5, 0, 0);
    vecs[34] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 'h0,   0, 5, 0, 0);
    vecs[35] = V(1, 0, 0, 1, 0, 3, 1, 0, 0,  1, 0, 'h0,   0, 5, 0, 0);
    vecs[36] = V(1, 0, 0, 2, 0, 6, 1, 0, 0,  1, 1, 'h0,   0, 5, 1, 3);
    vecs[37] = V(0, 0, 0, 0, 0, 0, 1, 1, 3,  1, 1, 'h2,   0, 5, 2, 6);
    vecs[38] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 'h4,   0, 5, 0, 0);
    vecs[39] = V(0, 0, 0, 0, 0, 0, 1, 1, 6,  1, 0, 'h4,   0, 5, 0, 0);
    vecs[40] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  1, 0, 'h0,   0, 5, 0, 0);
    vecs[41] = V(1, 0, 0, 3, 0, 0, 1, 0, 0,  1, 0, 'h0,   0, 5, 0, 0);
    vecs[42] = V(1, 0, 0, 4, 0, 1, 1, 0, 0,  1, 1, 'h0,   0, 5, 3, 0);
    vecs[43] = V(1, 3, 0, 9, 1, 2, 1, 0, 0,  1, 1, 'h8,   0, 5, 4, 1);
    vecs[44] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 'h18,  0, 5, 0, 0);
    vecs[45] = V(0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 'h18,  0, 6, 0, 0);

    rst_ni = 1'b0;
    issue_req_valid_i = 1'b0;
    issue_req_i = '0;
    launch_ready_i = 1'b0;
    done_i = 1'b0;
    done_insn_id_i = '0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      issue_req_valid_i   = vecs[i].iv;
      issue_req_i         = '0;
      issue_req_i.op      = 8'(8'hA0 + i);
      issue_req_i.vs1     = vecs[i].vs1;
      issue_req_i.vs2     = vecs[i].vs2;
      issue_req_i.vd      = vecs[i].vd;
      issue_req_i.use_vs  = vecs[i].use_vs;
      issue_req_i.insn_id = vecs[i].id;
      launch_ready_i      = vecs[i].lr;
      done_i              = vecs[i].dn;
      done_insn_id_i      = vecs[i].did;
      #1;
      n_vec++;
      chk("issue_ready", i, 32'(issue_req_ready_o), 32'(vecs[i].e_rdy));
      chk("launch_valid", i, 32'(launch_valid_o), 32'(vecs[i].e_lv));
      chk("busy", i, busy_o, vecs[i].e_busy);
      chk("spurious", i, 32'(spurious_done_o), 32'(vecs[i].e_sp));
      chk("stall_cnt", i, 32'(stall_cnt_o), 32'(vecs[i].e_stall));
      if (vecs[i].e_lv) begin
        chk("launch_vd", i, 32'(launch_req_o.vd), 32'(vecs[i].e_vd));
        chk("launch_id", i, 32'(launch_req_o.insn_id), 32'(vecs[i].e_id));
      end
    end

    // Asynchronous reset mid-operation: two registers busy, a stalled entry held.
    rst_ni = 1'b0;
    #1;
    n_vec++;
    chk("rst_busy", NV, busy_o, 32'h0);
    chk("rst_launch_valid", NV, 32'(launch_valid_o), 32'h0);
    chk("rst_stall_cnt", NV, 32'(stall_cnt_o), 32'h0);
    chk("rst_issue_ready", NV, 32'(issue_req_ready_o), 32'h1);
    chk("rst_spurious", NV, 32'(spurious_done_o), 32'h0);

    issue_req_valid_i = 1'b0;
    done_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    n_vec++;
    chk("post_rst_busy", NV + 1, busy_o, 32'h0);
    chk("post_rst_launch_valid", NV + 1, 32'(launch_valid_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
